// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: shift modes and controller states.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } shifter_state_t;

endpackage

// File: rtl/iterative_multi_mode_shifter_if.sv
// Valid/ready request and result channels of the iterative shifter.
interface iterative_multi_mode_shifter_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned SW = $clog2(N);

    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_shamt;
    logic [1:0]    up_mode;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;

    modport master (
        output up_valid, up_data, up_shamt, up_mode, down_ready,
        input  up_ready, down_valid, down_data
    );

    modport slave (
        input  up_valid, up_data, up_shamt, up_mode, down_ready,
        output up_ready, down_valid, down_data
    );

endinterface

// File: rtl/shifter_stage.sv
// One log2 stage: shifts or rotates by 2^k in the given mode when enabled.
module shifter_stage
    import shift_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  data,
    input  logic [SW-1:0] k,
    input  logic          enable,
    input  shift_mode_t   mode,
    output logic [N-1:0]  result
);

    logic [SW:0]  amt;
    logic [N-1:0] shifted;

    assign amt = (SW+1)'(1) << k;

    for (genvar i = 0; i < N; i++) begin : g_bit
        // hi_idx carries one extra bit so "source beyond MSB" is visible
        logic [SW:0]   hi_idx;
        logic [SW-1:0] lo_idx;
        logic          bit_out;

        assign hi_idx = (SW+1)'(i) + amt;
        assign lo_idx = SW'(i) - amt[SW-1:0];

        always_comb begin
            bit_out = 1'b0;
            case (mode)
                SHIFT_SLL: bit_out = ((SW+1)'(i) >= amt) ? data[lo_idx] : 1'b0;
                SHIFT_SRL: bit_out = hi_idx[SW] ? 1'b0 : data[hi_idx[SW-1:0]];
                SHIFT_SRA: bit_out = hi_idx[SW] ? data[N-1] : data[hi_idx[SW-1:0]];
                SHIFT_ROR: bit_out = data[hi_idx[SW-1:0]];
                default:   bit_out = 1'b0;
            endcase
        end

        assign shifted[i] = bit_out;
    end

    assign result = enable ? shifted : data;

endmodule

// File: rtl/iterative_multi_mode_shifter.sv
// Multi-cycle shifter: one stage per cycle, fixed latency of SW BUSY cycles.
module iterative_multi_mode_shifter
    import shift_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input logic                          clk,
    input logic                          rst,
    iterative_multi_mode_shifter_if.slave bus
);

    shifter_state_t state_q, state_d;
    logic [SW-1:0]  cnt_q;
    logic [SW-1:0]  shamt_q;
    shift_mode_t    mode_q;
    logic [N-1:0]   work_q;
    logic [N-1:0]   stage_out;
    logic           accept;

    assign accept = bus.up_valid && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.up_valid) state_d = BUSY;
            BUSY:    if (cnt_q == SW'(SW - 1)) state_d = DONE;
            DONE:    if (bus.down_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.up_ready   = (state_q == IDLE);
        bus.down_valid = (state_q == DONE);
        bus.down_data  = work_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shamt_q <= '0;
            mode_q  <= SHIFT_SLL;
            work_q  <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            shamt_q <= bus.up_shamt;
            mode_q  <= shift_mode_t'(bus.up_mode);
            work_q  <= bus.up_data;
        end else if (state_q == BUSY) begin
            cnt_q  <= cnt_q + 1'b1;
            work_q <= stage_out;
        end
    end

    shifter_stage #(
        .N(N)
    ) u_stage (
        .data   (work_q),
        .k      (cnt_q),
        .enable (shamt_q[cnt_q]),
        .mode   (mode_q),
        .result (stage_out)
    );

endmodule

// File: tb/tb_iterative_multi_mode_shifter.sv
// Self-checking bench: directed vectors, backpressure, mid-operation reset, random sweep N=8/32.
module tb_iterative_multi_mode_shifter;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    iterative_multi_mode_shifter_if #(.N(8))  b8 ();
    iterative_multi_mode_shifter_if #(.N(32)) b32 ();

    iterative_multi_mode_shifter #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    iterative_multi_mode_shifter #(.N(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          mode;
        logic [31:0] data;
        int          shamt;
        logic [31:0] exp;
        string       name;
    } vec_t;

    // Golden single-step shift on an n-bit value.
    function automatic logic [31:0] model(logic [31:0] d, int s, int m, int n);
        longint unsigned mask;
        longint unsigned v;
        longint unsigned r;
        longint          sv;
        mask = (64'd1 << n) - 64'd1;
        v    = {32'd0, d} & mask;
        case (m)
            0: r = (v << s) & mask;
            1: r = v >> s;
            2: begin
                sv = d[n-1] ? longint'(v | ~mask) : longint'(v);
                r  = longint'(sv >>> s) & mask;
            end
            default: r = ((v >> s) | (v << (n - s))) & mask;
        endcase
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rd_ur(int w);
        return w != 0 ? b32.up_ready : b8.up_ready;
    endfunction

    function automatic logic rd_dv(int w);
        return w != 0 ? b32.down_valid : b8.down_valid;
    endfunction

    function automatic logic [31:0] rd_dd(int w);
        return w != 0 ? b32.down_data : {24'd0, b8.down_data};
    endfunction

    task automatic set_req(input int w, input logic v, input logic [31:0] d, input int s,
                           input int m);
        logic [1:0] mm;
        mm = m[1:0];
        if (w != 0) begin
            b32.up_valid = v;
            b32.up_data  = d;
            b32.up_shamt = s[4:0];
            b32.up_mode  = mm;
        end else begin
            b8.up_valid = v;
            b8.up_data  = d[7:0];
            b8.up_shamt = s[2:0];
            b8.up_mode  = mm;
        end
    endtask

    task automatic set_dr(input int w, input logic r);
        if (w != 0) b32.down_ready = r;
        else        b8.down_ready = r;
    endtask

    // One full transaction; holds down_ready low for 'hold' cycles once the result is up.
    task automatic xact(input int w, input logic [31:0] d, input int s, input int m,
                        input logic [31:0] exp, input int hold, input string tag);
        int          n;
        int          sw;
        int          lat;
        logic [31:0] first;
        n  = (w != 0) ? 32 : 8;
        sw = (w != 0) ? 5 : 3;
        set_req(w, 1'b1, d, s, m);
        set_dr(w, 1'b0);
        chk({tag, ":accept_ready"}, 32'(rd_ur(w)), 32'd1);
        @(posedge clk); #1;
        set_req(w, 1'b0, $urandom, $urandom_range(0, n - 1), $urandom_range(0, 3));
        lat = 0;
        while (!rd_dv(w) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), 32'(sw));
        first = rd_dd(w);
        for (int i = 0; i < hold; i++) begin
            set_req(w, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, n - 1),
                    $urandom_range(0, 3));
            @(posedge clk); #1;
            chk({tag, ":hold_state"}, {30'd0, rd_dv(w), rd_ur(w)}, 32'd2);
            chk({tag, ":hold_data"}, rd_dd(w), first);
        end
        set_req(w, 1'b0, 32'd0, 0, 0);
        set_dr(w, 1'b1);
        @(posedge clk); #1;
        set_dr(w, 1'b0);
        chk({tag, ":after_xfer"}, {30'd0, rd_dv(w), rd_ur(w)}, 32'd1);
        chk({tag, ":result"}, first, exp);
    endtask

    vec_t tbl[7];
    int   quiet_hits;

    initial begin
        tests = 0;
        fails = 0;
        tbl[0] = '{0, 32'hB3, 3, 32'h98, "sll_b3_3"};
        tbl[1] = '{2, 32'h96, 2, 32'hE5, "sra_96_2"};
        tbl[2] = '{1, 32'h96, 2, 32'h25, "srl_96_2"};
        tbl[3] = '{1, 32'hF0, 0, 32'hF0, "srl_f0_0"};
        tbl[4] = '{3, 32'h96, 3, 32'hD2, "ror_96_3"};
        tbl[5] = '{3, 32'h81, 1, 32'hC0, "ror_81_1"};
        tbl[6] = '{0, 32'hFF, 7, 32'h80, "sll_ff_7"};

        rst = 1'b1;
        set_req(0, 1'b0, 32'd0, 0, 0);
        set_req(1, 1'b0, 32'd0, 0, 0);
        set_dr(0, 1'b0);
        set_dr(1, 1'b0);
        #3;
        chk("reset_state8", {30'd0, rd_dv(0), rd_ur(0)}, 32'd1);
        chk("reset_data8", rd_dd(0), 32'd0);
        chk("reset_state32", {30'd0, rd_dv(1), rd_ur(1)}, 32'd1);
        #19 rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) xact(0, tbl[i].data, tbl[i].shamt, tbl[i].mode, tbl[i].exp, 0, tbl[i].name);

        xact(0, 32'h5A, 4, 3, 32'hA5, 5, "backpressure");

        // Abort a request after one stage with an asynchronous reset between edges.
        set_req(0, 1'b1, 32'hC3, 5, 3);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 0, 0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("midbusy_rst_state", {30'd0, rd_dv(0), rd_ur(0)}, 32'd1);
        chk("midbusy_rst_data", rd_dd(0), 32'd0);
        #2 rst = 1'b0;
        set_dr(0, 1'b1);
        quiet_hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rd_dv(0)) quiet_hits++;
        end
        chk("no_aborted_result", 32'(quiet_hits), 32'd0);
        set_dr(0, 1'b0);
        xact(0, 32'h80, 7, 1, 32'h01, 0, "srl_80_7");

        for (int w = 0; w < 2; w++) begin
            for (int m = 0; m < 4; m++) begin
                for (int s = 0; s < ((w != 0) ? 32 : 8); s++) begin
                    logic [31:0] d;
                    d = $urandom;
                    if (w == 0) d = {24'd0, d[7:0]};
                    xact(w, d, s, m, model(d, s, m, (w != 0) ? 32 : 8),
                         $urandom_range(0, 2), "sweep");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
